fifo_write_packer: RTL and testbench

- Upstream stage of the 512-bit simulation FIFO.
- Accepts a narrow valid/ready stream with a last flag and packs RATIO input beats into one FIFO-width line.
- Drives the FIFO's wrreq/data and honours its full signal.
- A short packet is flushed as a zero-padded partial line, so no data is stranded between packets.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_write_packer.sv | 103 ++++++++++
 tb/tb_fifo_write_packer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and helpers for the simulation FIFO path
//
// Purpose: default widths for the 512-bit simulation FIFO and its write
// packer, plus a helper that sizes the beat-slot index.
// Ports: none (package).
package fifo_pkg;

  localparam int DEF_IN_WIDTH  = 64;
  localparam int DEF_OUT_WIDTH = 512;
  localparam int DEF_LOG_DEPTH = 9;

  // Width of an index that selects one of 'ratio' beat slots.
  // Never returns zero, so a 1:1 packer still has a legal vector.
  function automatic int slot_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_packer.sv
// rtl/fifo_write_packer.sv - packs narrow stream beats into FIFO-width lines
//
// Purpose: accepts IN_WIDTH beats and packs RATIO of them into one OUT_WIDTH
// line for the FIFO. The first beat lands in the LSBs. in_last flushes a
// short packet as a zero-padded partial line.
// Ports:
//   clock, reset_n    - rising-edge clock, asynchronous active-low reset
//   in_valid, in_data - input beat and its valid flag
//   in_last           - final beat of a packet; forces a line flush
//   in_ready          - beat accepted when in_valid && in_ready
//   wrreq, data       - FIFO enqueue strobe and line
//   full              - FIFO full
//   lines_written     - lines enqueued since reset
//   partial_lines     - lines flushed with fewer than RATIO beats
module fifo_write_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 wrreq,
  output logic [OUT_WIDTH-1:0] data,
  input  logic                 full,
  output logic [CNT_WIDTH-1:0] lines_written,
  output logic [CNT_WIDTH-1:0] partial_lines
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W = slot_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (OUT_WIDTH % IN_WIDTH != 0) begin : g_bad_ratio
      $fatal(1, "fifo_write_packer: OUT_WIDTH must be a multiple of IN_WIDTH");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] acc;
  logic [IDX_W-1:0]     idx;
  logic [OUT_WIDTH-1:0] line_q;
  logic                 line_valid;

  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] merged;

  // A pending line that drains this cycle frees the register for a new
  // completion in the same cycle, so in_ready only drops while full stalls it.
  assign in_ready = !line_valid || !full;
  assign wrreq    = line_valid && !full;
  assign data     = line_q;

  assign accept   = in_valid && in_ready;
  assign complete = accept && ((idx == LAST_IDX) || in_last);

  // acc is cleared on every completion, so slots above idx are already zero
  // and the merged value doubles as the zero-padded partial line.
  always_comb begin
    merged = acc;
    merged[idx*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      idx           <= '0;
      line_q        <= '0;
      line_valid    <= 1'b0;
      lines_written <= '0;
      partial_lines <= '0;
    end else begin
      if (complete) begin
        line_q     <= merged;
        line_valid <= 1'b1;
        idx        <= '0;
        acc        <= '0;
        if (idx != LAST_IDX) begin
          partial_lines <= partial_lines + 1'b1;
        end
      end else begin
        if (accept) begin
          acc <= merged;
          idx <= idx + 1'b1;
        end
        if (wrreq) begin
          line_valid <= 1'b0;
        end
      end

      if (wrreq) begin
        lines_written <= lines_written + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_packer.sv
// tb/tb_fifo_write_packer.sv - directed self-checking bench for fifo_write_packer
module tb_fifo_write_packer;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic [63:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         wrreq;
  logic [511:0] data;
  logic         full;
  logic [31:0]  lines_written;
  logic [31:0]  partial_lines;

  int tests;
  int fails;
  int cyc;
  int stalls;

  logic [511:0] fifo_q[$];
  logic [511:0] exp_q[$];
  int           wr_cycles[$];

  fifo_write_packer #(
    .IN_WIDTH (64),
    .OUT_WIDTH(512),
    .CNT_WIDTH(32)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .wrreq        (wrreq),
    .data         (data),
    .full         (full),
    .lines_written(lines_written),
    .partial_lines(partial_lines)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO model: every wrreq seen at a rising edge is one enqueued line.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (wrreq) begin
      fifo_q.push_back(data);
      wr_cycles.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [63:0] d, input logic last);
    int budget;
    budget   = 100;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    if (!in_ready) stalls++;
    while (!in_ready && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    if (budget == 0) check_eq("in_ready_wait", {511'b0, in_ready}, 512'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] base, input int n);
    logic [511:0] line;
    line = '0;
    for (int i = 0; i < n; i++) begin
      line[i*64 +: 64] = base + 64'(i);
      send(base + 64'(i), i == n - 1);
    end
    exp_q.push_back(line);
  endtask

  task automatic drain_check(input string tag);
    logic [511:0] got;
    logic [511:0] exp;
    check_eq({tag, "_count"}, 512'(fifo_q.size()), 512'(exp_q.size()));
    while (fifo_q.size() > 0 && exp_q.size() > 0) begin
      got = fifo_q.pop_front();
      exp = exp_q.pop_front();
      check_eq({tag, "_line"}, got, exp);
    end
    fifo_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] line;
    int base_n;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    stalls   = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    full     = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_wrreq", {511'b0, wrreq}, 512'd0);
    check_eq("rst_data", data, 512'd0);
    check_eq("rst_in_ready", {511'b0, in_ready}, 512'd1);
    check_eq("rst_lines", 512'(lines_written), 512'd0);
    check_eq("rst_partial", 512'(partial_lines), 512'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Full line: beats 0..7, wrreq one cycle after beat 7.
    send_pkt(64'h0, 8);
    #1;
    check_eq("full_wrreq", {511'b0, wrreq}, 512'd1);
    check_eq("full_data", data, {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0});
    @(negedge clock);
    #1;
    check_eq("full_wrreq_once", {511'b0, wrreq}, 512'd0);
    check_eq("full_lines", 512'(lines_written), 512'd1);
    check_eq("full_partial", 512'(partial_lines), 512'd0);
    drain_check("full");

    // Partial flush: A,B,C then zero padding.
    @(negedge clock);
    send_pkt(64'hA, 3);
    #1;
    check_eq("part_data", data, {320'b0, 64'hC, 64'hB, 64'hA});
    @(negedge clock);
    check_eq("part_partial", 512'(partial_lines), 512'd1);
    check_eq("part_lines", 512'(lines_written), 512'd2);
    drain_check("part");

    // Backpressure: line pending while full, beats offered but refused.
    for (int i = 0; i < 7; i++) send(64'h100 + 64'(i), 1'b0);
    full = 1'b1;
    send(64'h107, 1'b1);
    line = '0;
    for (int i = 0; i < 8; i++) line[i*64 +: 64] = 64'h100 + 64'(i);
    exp_q.push_back(line);
    in_valid = 1'b1;
    in_data  = 64'h200;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_wrreq", {511'b0, wrreq}, 512'd0);
      check_eq("bp_in_ready", {511'b0, in_ready}, 512'd0);
      check_eq("bp_data", data, line);
      @(negedge clock);
    end
    full = 1'b0;
    #1;
    check_eq("bp_release_wrreq", {511'b0, wrreq}, 512'd1);
    check_eq("bp_release_ready", {511'b0, in_ready}, 512'd1);
    send_pkt(64'h200, 8);
    repeat (2) @(negedge clock);
    check_eq("bp_lines", 512'(lines_written), 512'd4);
    drain_check("bp");

    // Streaming: 64 beats, last every 8th, no stalls, one line per 8 cycles.
    stalls = 0;
    base_n = wr_cycles.size();
    for (int p = 0; p < 8; p++) send_pkt(64'h1000 + 64'(p * 16), 8);
    repeat (2) @(negedge clock);
    check_eq("stream_stalls", 512'(stalls), 512'd0);
    check_eq("stream_wr_count", 512'(wr_cycles.size() - base_n), 512'd8);
    for (int i = base_n + 1; i < wr_cycles.size(); i++)
      check_eq("stream_gap", 512'(wr_cycles[i] - wr_cycles[i-1]), 512'd8);
    drain_check("stream");

    // Single-beat packets back to back.
    base_n = wr_cycles.size();
    for (int i = 0; i < 4; i++) send_pkt(64'h5000 + 64'(i), 1);
    repeat (2) @(negedge clock);
    check_eq("single_wr_count", 512'(wr_cycles.size() - base_n), 512'd4);
    if (wr_cycles.size() - base_n == 4)
      check_eq("single_consecutive", 512'(wr_cycles[base_n+3] - wr_cycles[base_n]), 512'd3);
    check_eq("single_partial", 512'(partial_lines), 512'd5);
    drain_check("single");

    // Reset mid-packet: 5 beats then asynchronous reset.
    for (int i = 0; i < 5; i++) send(64'h300 + 64'(i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_wrreq", {511'b0, wrreq}, 512'd0);
    check_eq("mid_rst_ready", {511'b0, in_ready}, 512'd1);
    check_eq("mid_rst_data", data, 512'd0);
    check_eq("mid_rst_lines", 512'(lines_written), 512'd0);
    @(negedge clock);
    fifo_q.delete();
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
    send_pkt(64'h400, 8);
    repeat (2) @(negedge clock);
    check_eq("post_rst_lines", 512'(lines_written), 512'd1);
    check_eq("post_rst_partial", 512'(partial_lines), 512'd0);
    drain_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
